// File: rtl/exhaust_sweep_gen_pkg.sv
// exhaust_sweep_gen_pkg
// Shared types and helpers for the exhaustive sweep generator:
//   state_e    - sweep controller states
//   bin2gray   - 8-bit binary to reflected Gray code
//   popcount   - number of set bits in an 8-bit value
//   ones_w     - width of a counter able to hold 0..tw
//   hold_w     - width of the per-vector hold counter (never 0)
package exhaust_sweep_gen_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        DONE  = 2'd2
    } state_e;

    function automatic logic [7:0] bin2gray(input logic [7:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [3:0] popcount(input logic [7:0] v);
        logic [3:0] c;
        c = 4'd0;
        for (int i = 0; i < 8; i++) c = c + {3'b000, v[i]};
        return c;
    endfunction

    function automatic int ones_w(input int tw);
        return $clog2(tw + 1);
    endfunction

    function automatic int hold_w(input int h);
        return (h > 1) ? $clog2(h) : 1;
    endfunction

endpackage

// File: rtl/exhaust_sweep_gen_if.sv
// exhaust_sweep_gen_if
// Control, stimulus/response and result bundle of the sweep generator.
//   start/mode/abort        - sweep control from the host
//   stim/stim_valid         - vector driven into the DUT under sweep
//   resp                    - DUT response
//   busy/done               - sweep status
//   truth_tbl/ones_cnt      - captured table and its ones count
// With SWEEP_EXPECT_EN defined: exp_tbl (expected table), mismatch, first_fail.
// master: the generator; slave: the host/DUT environment.
interface exhaust_sweep_gen_if #(
    parameter int N_IN  = 4,
    parameter int N_OUT = 1
);
    localparam int TW = N_OUT << N_IN;
    localparam int CW = $clog2(TW + 1);

    logic             start;
    logic             mode;
    logic             abort;
    logic [N_IN-1:0]  stim;
    logic             stim_valid;
    logic [N_OUT-1:0] resp;
    logic             busy;
    logic             done;
    logic [TW-1:0]    truth_tbl;
    logic [CW-1:0]    ones_cnt;
`ifdef SWEEP_EXPECT_EN
    logic [TW-1:0]    exp_tbl;
    logic             mismatch;
    logic [N_IN-1:0]  first_fail;
`endif

    modport master (
        input  start, mode, abort, resp,
`ifdef SWEEP_EXPECT_EN
        input  exp_tbl,
        output mismatch, first_fail,
`endif
        output stim, stim_valid, busy, done, truth_tbl, ones_cnt
    );

    modport slave (
        output start, mode, abort, resp,
`ifdef SWEEP_EXPECT_EN
        output exp_tbl,
        input  mismatch, first_fail,
`endif
        input  stim, stim_valid, busy, done, truth_tbl, ones_cnt
    );

endinterface

// File: rtl/exhaust_sweep_gen_seq.sv
// sweep_seq
// Vector index / hold counters and the stimulus encoder.
//   clk, rst  - clock, async active-high reset
//   load_i    - start a sweep: index 0, hold 0, latch mode_i, stim 0
//   mode_i    - 0 binary order, 1 Gray order
//   run_i     - advance counters this cycle (APPLY and not aborting)
//   stim_o    - registered vector map(idx)
//   cap_o     - this is the last hold cycle of the current vector
//   last_o    - current vector is the final one of the sweep
module sweep_seq
    import exhaust_sweep_gen_pkg::*;
#(
    parameter int N_IN        = 4,
    parameter int HOLD_CYCLES = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load_i,
    input  logic            mode_i,
    input  logic            run_i,
    output logic [N_IN-1:0] stim_o,
    output logic            cap_o,
    output logic            last_o
);
    localparam int IW = N_IN + 1;  // one spare bit so the final index never aliases 0
    localparam int HW = hold_w(HOLD_CYCLES);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'((1 << N_IN) - 1);

    logic [IW-1:0]   idx_q,  idx_d;
    logic [HW-1:0]   hold_q;
    logic            mode_q;
    logic [N_IN-1:0] stim_q, stim_d;
    logic [N_IN-1:0] nxt;
    logic [7:0]      gray;

    always_comb begin
        idx_d  = idx_q + IW'(1);
        nxt    = idx_q[N_IN-1:0] + N_IN'(1);
        gray   = bin2gray(8'(nxt));
        stim_d = mode_q ? gray[N_IN-1:0] : nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q  <= '0;
            hold_q <= '0;
            mode_q <= 1'b0;
            stim_q <= '0;
        end else if (load_i) begin
            idx_q  <= '0;
            hold_q <= '0;
            mode_q <= mode_i;
            stim_q <= '0;
        end else if (run_i) begin
            if (hold_q == HOLD_LAST) begin
                hold_q <= '0;
                // on the final vector stim holds its last value
                if (idx_q != IDX_LAST) begin
                    idx_q  <= idx_d;
                    stim_q <= stim_d;
                end
            end else begin
                hold_q <= hold_q + HW'(1);
            end
        end
    end

    assign stim_o = stim_q;
    assign cap_o  = (hold_q == HOLD_LAST);
    assign last_o = (idx_q == IDX_LAST);

endmodule

// File: rtl/exhaust_sweep_gen.sv
// exhaust_sweep_gen
// Exhaustive stimulus generator and truth-table capture engine. Drives every
// N_IN-bit vector (binary or Gray order), holds each HOLD_CYCLES cycles,
// samples resp on the last hold cycle into truth_tbl at address stim, and
// accumulates the ones count.
// Ports:
//   clk    - clock, rising edge
//   rst    - asynchronous reset, active-high
//   sweep  - exhaust_sweep_gen_if.master (start, mode, abort, stim,
//            stim_valid, resp, busy, done, truth_tbl, ones_cnt)
// Optional: define SWEEP_EXPECT_EN to compare each capture against exp_tbl
// and report a sticky mismatch flag plus the first failing vector.
module exhaust_sweep_gen
    import exhaust_sweep_gen_pkg::*;
#(
    parameter int N_IN        = 4,
    parameter int N_OUT       = 1,
    parameter int HOLD_CYCLES = 1
) (
    input  logic                clk,
    input  logic                rst,
    exhaust_sweep_gen_if.master sweep
);
    localparam int DEPTH = 1 << N_IN;
    localparam int TW    = N_OUT * DEPTH;
    localparam int CW    = ones_w(TW);

    state_e          state_q;
    logic            stim_valid_q, busy_q, done_q;
    logic [TW-1:0]   tbl_q;
    logic [CW-1:0]   ones_q;
    logic [N_IN-1:0] stim;
    logic            cap_pt, last;
    logic            load, run, cap;

    assign load = (state_q == IDLE)  && sweep.start;
    assign run  = (state_q == APPLY) && !sweep.abort;  // abort outranks capture
    assign cap  = run && cap_pt;

    sweep_seq #(
        .N_IN        (N_IN),
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_seq (
        .clk    (clk),
        .rst    (rst),
        .load_i (load),
        .mode_i (sweep.mode),
        .run_i  (run),
        .stim_o (stim),
        .cap_o  (cap_pt),
        .last_o (last)
    );

`ifdef SWEEP_EXPECT_EN
    logic             mismatch_q;
    logic [N_IN-1:0]  first_fail_q;
    logic [N_OUT-1:0] exp_sel;

    always_comb begin
        exp_sel = '0;
        for (int v = 0; v < DEPTH; v++)
            if (int'(stim) == v) exp_sel = sweep.exp_tbl[v*N_OUT +: N_OUT];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mismatch_q   <= 1'b0;
            first_fail_q <= '0;
        end else if (load) begin
            mismatch_q   <= 1'b0;
            first_fail_q <= '0;
        end else if (cap && !mismatch_q && (exp_sel != sweep.resp)) begin
            mismatch_q   <= 1'b1;
            first_fail_q <= stim;
        end
    end

    assign sweep.mismatch   = mismatch_q;
    assign sweep.first_fail = first_fail_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            stim_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            tbl_q        <= '0;
            ones_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (sweep.start) begin
                        state_q      <= APPLY;
                        stim_valid_q <= 1'b1;
                        busy_q       <= 1'b1;
                        tbl_q        <= '0;
                        ones_q       <= '0;
                    end
                end
                APPLY: begin
                    if (sweep.abort) begin
                        state_q      <= IDLE;
                        stim_valid_q <= 1'b0;
                        busy_q       <= 1'b0;
                    end else if (cap) begin
                        // indexed by stim, so the table is order-independent
                        for (int v = 0; v < DEPTH; v++)
                            if (int'(stim) == v) tbl_q[v*N_OUT +: N_OUT] <= sweep.resp;
                        ones_q <= ones_q + CW'(popcount(8'(sweep.resp)));
                        if (last) begin
                            state_q      <= DONE;
                            stim_valid_q <= 1'b0;
                            busy_q       <= 1'b0;
                            done_q       <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign sweep.stim       = stim;
    assign sweep.stim_valid = stim_valid_q;
    assign sweep.busy       = busy_q;
    assign sweep.done       = done_q;
    assign sweep.truth_tbl  = tbl_q;
    assign sweep.ones_cnt   = ones_q;

endmodule

// File: tb/tb_exhaust_sweep_gen.sv
// Directed bench for exhaust_sweep_gen: one instance with HOLD_CYCLES=1 and
// a selectable combinational DUT, one with HOLD_CYCLES=3 fed by a registered
// stim[0]. Expected-value checks run only when SWEEP_EXPECT_EN is defined.
module tb_exhaust_sweep_gen;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   sel   = 0;  // 0: f=s3&s2|s1&~s0, 1: f=1, 2: f with entry 6 flipped

    always #5 clk = ~clk;

    exhaust_sweep_gen_if #(.N_IN(4), .N_OUT(1)) bus  ();
    exhaust_sweep_gen_if #(.N_IN(4), .N_OUT(1)) bus3 ();

    exhaust_sweep_gen #(.N_IN(4), .N_OUT(1), .HOLD_CYCLES(1)) u_dut (
        .clk (clk), .rst (rst), .sweep (bus));
    exhaust_sweep_gen #(.N_IN(4), .N_OUT(1), .HOLD_CYCLES(3)) u_dut3 (
        .clk (clk), .rst (rst), .sweep (bus3));

    always_comb begin
        case (sel)
            1:       bus.resp = 1'b1;
            2:       bus.resp = ((bus.stim[3] & bus.stim[2]) | (bus.stim[1] & ~bus.stim[0]))
                                ^ (bus.stim == 4'd6);
            default: bus.resp = (bus.stim[3] & bus.stim[2]) | (bus.stim[1] & ~bus.stim[0]);
        endcase
    end

    always_ff @(posedge clk) bus3.resp <= bus3.stim[0];

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.start = 0; bus.mode = 0; bus.abort = 0;
        bus3.start = 0; bus3.mode = 0; bus3.abort = 0;
`ifdef SWEEP_EXPECT_EN
        bus.exp_tbl = 16'hF444; bus3.exp_tbl = 16'hAAAA;
`endif
        step; step;
        total++;
        if ({bus.stim, bus.stim_valid, bus.busy, bus.done} !== 7'd0) begin
            bad++; $display("FAIL reset_ctl got=%h want=0", {bus.stim, bus.stim_valid, bus.busy, bus.done});
        end
        total++;
        if ({bus.truth_tbl, bus.ones_cnt} !== 21'd0) begin
            bad++; $display("FAIL reset_tbl got=%h want=0", {bus.truth_tbl, bus.ones_cnt});
        end
        rst = 1'b0;
        step;
    endtask

    task automatic sweep16(input string nm, input logic m, input logic [3:0] seq [16]);
        bus.mode = m; bus.start = 1; step; bus.start = 0;
        total++;
        if ({bus.stim_valid, bus.busy} !== 2'b11) begin
            bad++; $display("FAIL %s_busy got=%b want=11", nm, {bus.stim_valid, bus.busy});
        end
        for (int k = 0; k < 16; k++) begin
            total++;
            if (bus.stim !== seq[k] || bus.done !== 1'b0) begin
                bad++; $display("FAIL %s_stim k=%0d got=%0d want=%0d", nm, k, bus.stim, seq[k]);
            end
            step;
        end
        // done on the 17th edge counting the one that sampled start
        total++;
        if ({bus.done, bus.busy, bus.stim_valid} !== 3'b100 || bus.stim !== seq[15]) begin
            bad++; $display("FAIL %s_done got=%b stim=%0d want=100 stim=%0d", nm,
                            {bus.done, bus.busy, bus.stim_valid}, bus.stim, seq[15]);
        end
        step;
        total++;
        if (bus.done !== 1'b0) begin
            bad++; $display("FAIL %s_done_pulse got=%b want=0", nm, bus.done);
        end
        total++;
        if (bus.truth_tbl !== 16'hF444 || bus.ones_cnt !== 5'd7) begin
            bad++; $display("FAIL %s_tbl got=%h/%0d want=f444/7", nm, bus.truth_tbl, bus.ones_cnt);
        end
    endtask

    task automatic test_binary;
        logic [3:0] seq [16];
        for (int k = 0; k < 16; k++) seq[k] = 4'(k);
        sel = 0;
        sweep16("binary", 1'b0, seq);
    endtask

    task automatic test_gray;
        logic [3:0] seq [16] = '{0,1,3,2,6,7,5,4,12,13,15,14,10,11,9,8};
        sel = 0;
        sweep16("gray", 1'b1, seq);
        bus.mode = 0;
    endtask

    task automatic test_hold3;
        int cnt = 0;
        bit seen = 0;
        bus3.start = 1; step; bus3.start = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            if (bus3.done) seen = 1;
            else begin
                if (bus3.stim_valid) begin
                    total++;
                    if (bus3.stim !== 4'(cnt / 3)) begin
                        bad++; $display("FAIL hold3_stim cyc=%0d got=%0d want=%0d", cnt, bus3.stim, cnt / 3);
                    end
                    cnt++;
                end
                step;
            end
        end
        total++;
        if (!seen) begin
            bad++; $display("FAIL hold3_timeout got=no_done want=done");
        end
        total++;
        if (cnt != 48) begin
            bad++; $display("FAIL hold3_len got=%0d want=48", cnt);
        end
        total++;
        if (bus3.truth_tbl !== 16'hAAAA || bus3.ones_cnt !== 5'd8) begin
            bad++; $display("FAIL hold3_tbl got=%h/%0d want=aaaa/8", bus3.truth_tbl, bus3.ones_cnt);
        end
        step;
    endtask

    task automatic test_abort;
        sel = 1;
        bus.start = 1; step; bus.start = 0;
        repeat (5) step;
        total++;
        if (bus.stim !== 4'd5 || bus.busy !== 1'b1) begin
            bad++; $display("FAIL abort_pre got=%0d/%b want=5/1", bus.stim, bus.busy);
        end
        bus.abort = 1; step; bus.abort = 0;
        total++;
        if ({bus.busy, bus.stim_valid, bus.done} !== 3'b000) begin
            bad++; $display("FAIL abort_idle got=%b want=000", {bus.busy, bus.stim_valid, bus.done});
        end
        step;
        total++;
        if (bus.done !== 1'b0 || bus.truth_tbl !== 16'h001F || bus.ones_cnt !== 5'd5) begin
            bad++; $display("FAIL abort_tbl got=%b/%h/%0d want=0/001f/5", bus.done, bus.truth_tbl, bus.ones_cnt);
        end
        // abort while idle does nothing
        bus.abort = 1; step; bus.abort = 0;
        total++;
        if (bus.truth_tbl !== 16'h001F || bus.busy !== 1'b0) begin
            bad++; $display("FAIL abort_noop got=%h/%b want=001f/0", bus.truth_tbl, bus.busy);
        end
        sel = 0;
    endtask

    task automatic test_reset_mid;
        sel = 0;
        bus.start = 1; step; bus.start = 0;
        repeat (9) step;
        total++;
        if (bus.stim !== 4'd9) begin
            bad++; $display("FAIL rstmid_pre got=%0d want=9", bus.stim);
        end
        #2 rst = 1;
        #1;
        total++;
        if ({bus.stim, bus.stim_valid, bus.busy, bus.done, bus.truth_tbl, bus.ones_cnt} !== 28'd0) begin
            bad++; $display("FAIL rstmid_async got=%h want=0",
                            {bus.stim, bus.stim_valid, bus.busy, bus.done, bus.truth_tbl, bus.ones_cnt});
        end
        step; rst = 0; step;
        // clean sweep with a stray start and a mode flip part-way through
        bus.start = 1; step; bus.start = 0;
        for (int k = 0; k < 16; k++) begin
            bus.start = (k == 5);
            bus.mode  = (k >= 7);
            total++;
            if (bus.stim !== 4'(k)) begin
                bad++; $display("FAIL rstmid_stim k=%0d got=%0d want=%0d", k, bus.stim, k);
            end
            step;
        end
        bus.start = 0; bus.mode = 0;
        total++;
        if (bus.done !== 1'b1 || bus.truth_tbl !== 16'hF444 || bus.ones_cnt !== 5'd7) begin
            bad++; $display("FAIL rstmid_sweep got=%b/%h/%0d want=1/f444/7", bus.done, bus.truth_tbl, bus.ones_cnt);
        end
        step;
    endtask

`ifdef SWEEP_EXPECT_EN
    task automatic test_expect;
        sel = 2;
        bus.start = 1; step; bus.start = 0;
        for (int k = 0; k < 16; k++) begin
            if (k == 6) begin
                total++;
                if (bus.mismatch !== 1'b0) begin
                    bad++; $display("FAIL expect_pre got=%b want=0", bus.mismatch);
                end
            end
            step;
            if (k == 6) begin
                total++;
                if (bus.mismatch !== 1'b1 || bus.first_fail !== 4'd6) begin
                    bad++; $display("FAIL expect_hit got=%b/%0d want=1/6", bus.mismatch, bus.first_fail);
                end
            end
        end
        total++;
        if (bus.mismatch !== 1'b1 || bus.first_fail !== 4'd6 || bus.truth_tbl !== 16'hF404) begin
            bad++; $display("FAIL expect_sticky got=%b/%0d/%h want=1/6/f404", bus.mismatch, bus.first_fail, bus.truth_tbl);
        end
        step;
        sel = 0;
        bus.start = 1; step; bus.start = 0;
        repeat (17) step;
        total++;
        if (bus.mismatch !== 1'b0 || bus.truth_tbl !== 16'hF444) begin
            bad++; $display("FAIL expect_clean got=%b/%h want=0/f444", bus.mismatch, bus.truth_tbl);
        end
    endtask
`endif

    initial begin
        test_reset;
        test_binary;
        test_gray;
        test_hold3;
        test_abort;
        test_reset_mid;
`ifdef SWEEP_EXPECT_EN
        test_expect;
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule
